mic1_mem_if: RTL and testbench

- Memory-interface stage downstream of the MIC-1 microinstruction register.
- Consumes the WRITE/READ/FETCH bits of each microinstruction together with the MAR, MDR and PC values.
- Runs the corresponding transactions on a single shared external memory port with a req/ready handshake.
- Returns read words to MDR and fetched bytes to MBR, and stalls the microsequencer while any transaction is outstanding.

---
 rtl/mic1_mem_if.sv | 212 +++++++++++++++++++++
 tb/tb_mic1_mem_if.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_mem_if.sv
// rtl/mic1_mem_if.sv - MIC-1 memory interface: sequences word and fetch accesses on one shared port
module mic1_mem_if #(
    parameter int unsigned TIMEOUT            = 255,
    parameter bit          FETCH_BYTE_LANE_LE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd,
    input  logic        wr,
    input  logic        fetch,
    input  logic [31:0] mar,
    input  logic [31:0] mdr_wr,
    input  logic [31:0] pc,
    output logic [31:0] mdr_rd,
    output logic        mdr_load,
    output logic [7:0]  mbr_byte,
    output logic        mbr_load,
    output logic        stall,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WORD  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   faddr_q, faddr_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          op_wr_q, op_wr_d;
    logic          fetch_pend_q, fetch_pend_d;
    logic          stall_q, stall_d;
    logic [31:0]   mdr_rd_q, mdr_rd_d;
    logic          mdr_load_q, mdr_load_d;
    logic [7:0]    mbr_byte_q, mbr_byte_d;
    logic          mbr_load_q, mbr_load_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    logic          busy;
    logic          done;
    logic          tmo;
    logic [1:0]    lane;
    logic [7:0]    fetch_byte;

    // Pick the fetched byte out of the returned word according to endianness
    always_comb begin
        lane = FETCH_BYTE_LANE_LE ? lane_q : (2'd3 - lane_q);
        fetch_byte = 8'h00;
        case (lane)
            2'd0:    fetch_byte = mem_rdata[7:0];
            2'd1:    fetch_byte = mem_rdata[15:8];
            2'd2:    fetch_byte = mem_rdata[23:16];
            default: fetch_byte = mem_rdata[31:24];
        endcase
    end

    // Next-state logic: accept a microinstruction, run word op then fetch, handle completion and timeout
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        faddr_d      = faddr_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        op_wr_d      = op_wr_q;
        fetch_pend_d = fetch_pend_q;
        stall_d      = stall_q;
        mdr_rd_d     = mdr_rd_q;
        mdr_load_d   = 1'b0;
        mbr_byte_d   = mbr_byte_q;
        mbr_load_d   = 1'b0;
        bus_err_d    = bus_err_q;
        tcnt_d       = tcnt_q;

        busy = (state_q != ST_IDLE);
        done = busy && mem_ready;
        // Aborts on the wait cycle that would bring the count up to TIMEOUT
        tmo  = (TIMEOUT != 0) && busy && !mem_ready && (tcnt_q == CW'(TIMEOUT - 1));

        if (busy && !mem_ready && (TIMEOUT != 0)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!stall_q && (rd || wr || fetch)) begin
                    waddr_d      = {mar[29:0], 2'b00};
                    faddr_d      = {pc[31:2], 2'b00};
                    lane_d       = pc[1:0];
                    wdata_d      = mdr_wr;
                    // rd together with wr resolves to a write and flags the conflict
                    op_wr_d      = wr;
                    fetch_pend_d = fetch;
                    bus_err_d    = bus_err_q | (rd & wr);
                    stall_d      = 1'b1;
                    tcnt_d       = '0;
                    state_d      = (rd || wr) ? ST_WORD : ST_FETCH;
                end
            end
            ST_WORD: begin
                if (done || tmo) begin
                    if (done && !op_wr_q) begin
                        mdr_rd_d   = mem_rdata;
                        mdr_load_d = 1'b1;
                    end
                    if (tmo) begin
                        bus_err_d = 1'b1;
                    end
                    tcnt_d  = '0;
                    stall_d = fetch_pend_q;
                    state_d = fetch_pend_q ? ST_FETCH : ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (done || tmo) begin
                    if (done) begin
                        mbr_byte_d = fetch_byte;
                        mbr_load_d = 1'b1;
                    end
                    if (tmo) begin
                        bus_err_d = 1'b1;
                    end
                    tcnt_d       = '0;
                    fetch_pend_d = 1'b0;
                    stall_d      = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                stall_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            faddr_q      <= '0;
            lane_q       <= '0;
            wdata_q      <= '0;
            op_wr_q      <= 1'b0;
            fetch_pend_q <= 1'b0;
            stall_q      <= 1'b0;
            mdr_rd_q     <= '0;
            mdr_load_q   <= 1'b0;
            mbr_byte_q   <= '0;
            mbr_load_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            faddr_q      <= faddr_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            op_wr_q      <= op_wr_d;
            fetch_pend_q <= fetch_pend_d;
            stall_q      <= stall_d;
            mdr_rd_q     <= mdr_rd_d;
            mdr_load_q   <= mdr_load_d;
            mbr_byte_q   <= mbr_byte_d;
            mbr_load_q   <= mbr_load_d;
            bus_err_q    <= bus_err_d;
            tcnt_q       <= tcnt_d;
        end
    end

    // External port driven purely from the registered state so it stays stable through wait states
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WORD: begin
                mem_req   = 1'b1;
                mem_we    = op_wr_q;
                mem_addr  = waddr_q;
                mem_wdata = op_wr_q ? wdata_q : 32'h0;
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = faddr_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign mdr_rd   = mdr_rd_q;
    assign mdr_load = mdr_load_q;
    assign mbr_byte = mbr_byte_q;
    assign mbr_load = mbr_load_q;
    assign stall    = stall_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mic1_mem_if.sv
// tb/tb_mic1_mem_if.sv - self-checking bench for mic1_mem_if
module tb_mic1_mem_if;

    localparam int TMO  = 4;
    localparam int HANG = 1000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rd, wr, fetch;
    logic [31:0] mar, mdr_wr, pc;
    logic [31:0] mdr_rd;
    logic        mdr_load;
    logic [7:0]  mbr_byte;
    logic        mbr_load;
    logic        stall;
    logic        bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    mic1_mem_if #(.TIMEOUT(TMO), .FETCH_BYTE_LANE_LE(1'b1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd        (rd),
        .wr        (wr),
        .fetch     (fetch),
        .mar       (mar),
        .mdr_wr    (mdr_wr),
        .pc        (pc),
        .mdr_rd    (mdr_rd),
        .mdr_load  (mdr_load),
        .mbr_byte  (mbr_byte),
        .mbr_load  (mbr_load),
        .stall     (stall),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          wait_cfg = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_mdr = '0;
    logic [7:0]  m_mbr = '0;
    logic        m_err = 1'b0;

    typedef struct {
        logic        r, w, f, hold;
        logic [31:0] mar, mdr, pc;
        int          ws;
        int          exp_stall, exp_mdr_ld, exp_mbr_ld;
        logic [31:0] exp_mdr;
        logic [7:0]  exp_mbr;
        logic        exp_err;
    } vec_t;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: wait_cfg wait states per transaction, or never ready when >= HANG
    initial begin : responder
        int          left;
        logic        in_txn;
        logic        cpend;
        logic [31:0] caddr, cdata;
        left = 0; in_txn = 1'b0; cpend = 1'b0; caddr = '0; cdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cpend && resetn) mem[caddr] = cdata;
            cpend = 1'b0;
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    left   = wait_cfg;
                end
                if (wait_cfg >= HANG || left > 0) begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    if (left > 0) left--;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_read(mem_addr);
                    if (mem_we) begin
                        cpend = 1'b1;
                        caddr = mem_addr;
                        cdata = mem_wdata;
                    end
                    in_txn = 1'b0;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                in_txn    = 1'b0;
            end
        end
    end

    // One microinstruction: predict from transaction-level rules, drive, observe, compare
    task automatic do_op(input logic r, input logic w, input logic f, input logic hold,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                         input int ws, output int o_stall, output int o_mdr_ld, output int o_mbr_ld);
        logic [31:0] sa[$];
        logic        sw[$];
        logic [31:0] sd[$];
        logic [31:0] waddr, faddr, fword;
        logic        word, tmo;
        int          len, total, n_req, bad, c, mdr_cyc, mbr_cyc;
        int          exp_mdr_ld, exp_mbr_ld, exp_mdr_cyc;

        word  = r | w;
        tmo   = (ws >= TMO);
        len   = tmo ? TMO : ws + 1;
        waddr = a << 2;
        faddr = p & ~32'h3;
        total = 0; exp_mdr_ld = 0; exp_mbr_ld = 0; exp_mdr_cyc = 0;
        if (word) begin
            for (int i = 0; i < len; i++) begin
                sa.push_back(waddr);
                sw.push_back(w);
                sd.push_back(w ? d : 32'h0);
            end
            total = total + len;
            if (r && !w && !tmo) begin
                exp_mdr_ld  = 1;
                exp_mdr_cyc = len;
                m_mdr       = mem_read(waddr);
            end
        end
        if (f) begin
            for (int i = 0; i < len; i++) begin
                sa.push_back(faddr);
                sw.push_back(1'b0);
                sd.push_back(32'h0);
            end
            total = total + len;
            if (!tmo) begin
                fword      = (w && waddr == faddr) ? d : mem_read(faddr);
                m_mbr      = 8'(fword >> (8 * p[1:0]));
                exp_mbr_ld = 1;
            end
        end
        if ((r && w) || (tmo && (word || f))) m_err = 1'b1;

        wait_cfg = ws;
        @(negedge clk);
        rd = r; wr = w; fetch = f; mar = a; mdr_wr = d; pc = p;
        @(posedge clk);
        #1;
        rd = hold; wr = 1'b0; fetch = 1'b0;
        mar = $urandom; mdr_wr = $urandom; pc = $urandom;

        n_req = 0; bad = 0; mdr_cyc = -1; mbr_cyc = -1;
        o_stall = 0; o_mdr_ld = 0; o_mbr_ld = 0;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mdr_load) begin o_mdr_ld++; mdr_cyc = c; end
            if (mbr_load) begin o_mbr_ld++; mbr_cyc = c; end
            if (mem_req) begin
                n_req++;
                if (c >= sa.size()) bad++;
                else if (mem_addr !== sa[c] || mem_we !== sw[c] || mem_wdata !== sd[c]) bad++;
            end
            if (stall) o_stall++;
            else break;
        end
        rd = 1'b0;
        if (c >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL op_bound: stall still high after 200 cycles at %0t", $time);
        end

        chk("op_stall", o_stall, total);
        chk("op_req_cycles", n_req, total);
        chk("op_bus_bad_cycles", bad, 0);
        chk("op_mdr_ld", o_mdr_ld, exp_mdr_ld);
        if (exp_mdr_ld == 1) chk("op_mdr_ld_cycle", mdr_cyc, exp_mdr_cyc);
        chk("op_mbr_ld", o_mbr_ld, exp_mbr_ld);
        if (exp_mbr_ld == 1) chk("op_mbr_ld_cycle", mbr_cyc, total);
        chk("op_mdr_rd", mdr_rd, m_mdr);
        chk("op_mbr_byte", 32'(mbr_byte), 32'(m_mbr));
        chk("op_bus_err", 32'(bus_err), 32'(m_err));
        @(negedge clk);
        if (w && !tmo) chk("op_mem_written", mem_read(waddr), d);
        chk("op_idle_after", 32'({stall, mem_req, mdr_load, mbr_load}), 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t vt[5];
        int   st, ml, bl;

        resetn = 1'b0;
        rd = 1'b0; wr = 1'b0; fetch = 1'b0;
        mar = '0; mdr_wr = '0; pc = '0;
        mem[32'h40]  = 32'hDEADBEEF;
        mem[32'h4]   = 32'hAABBCCDD;
        mem[32'h104] = 32'h11223344;

        vt[0] = '{r:1'b1, w:1'b0, f:1'b0, hold:1'b0, mar:32'h10, mdr:32'h0, pc:32'h0, ws:0,
                  exp_stall:1, exp_mdr_ld:1, exp_mbr_ld:0, exp_mdr:32'hDEADBEEF, exp_mbr:8'h00, exp_err:1'b0};
        vt[1] = '{r:1'b0, w:1'b1, f:1'b0, hold:1'b0, mar:32'h3, mdr:32'h12345678, pc:32'h0, ws:3,
                  exp_stall:4, exp_mdr_ld:0, exp_mbr_ld:0, exp_mdr:32'hDEADBEEF, exp_mbr:8'h00, exp_err:1'b0};
        vt[2] = '{r:1'b1, w:1'b0, f:1'b1, hold:1'b0, mar:32'h1, mdr:32'h0, pc:32'h106, ws:0,
                  exp_stall:2, exp_mdr_ld:1, exp_mbr_ld:1, exp_mdr:32'hAABBCCDD, exp_mbr:8'h22, exp_err:1'b0};
        vt[3] = '{r:1'b1, w:1'b1, f:1'b0, hold:1'b1, mar:32'h20, mdr:32'h55, pc:32'h0, ws:0,
                  exp_stall:1, exp_mdr_ld:0, exp_mbr_ld:0, exp_mdr:32'hAABBCCDD, exp_mbr:8'h22, exp_err:1'b1};
        vt[4] = '{r:1'b0, w:1'b0, f:1'b1, hold:1'b0, mar:32'h0, mdr:32'h0, pc:32'h200, ws:HANG,
                  exp_stall:4, exp_mdr_ld:0, exp_mbr_ld:0, exp_mdr:32'hAABBCCDD, exp_mbr:8'h22, exp_err:1'b1};

        repeat (3) @(negedge clk);
        chk("rst_mdr_rd", mdr_rd, 32'h0);
        chk("rst_outs", 32'({mdr_load, mbr_load, stall, bus_err, mem_req, mem_we}), 32'h0);
        chk("rst_mbr_byte", 32'(mbr_byte), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_op(vt[i].r, vt[i].w, vt[i].f, vt[i].hold, vt[i].mar, vt[i].mdr, vt[i].pc, vt[i].ws, st, ml, bl);
            chk("tbl_stall", st, vt[i].exp_stall);
            chk("tbl_mdr_ld", ml, vt[i].exp_mdr_ld);
            chk("tbl_mbr_ld", bl, vt[i].exp_mbr_ld);
            chk("tbl_mdr_rd", mdr_rd, vt[i].exp_mdr);
            chk("tbl_mbr_byte", 32'(mbr_byte), 32'(vt[i].exp_mbr));
            chk("tbl_bus_err", 32'(bus_err), 32'(vt[i].exp_err));
        end

        // Reset in the middle of a word wait state
        wait_cfg = HANG;
        @(negedge clk);
        rd = 1'b1; mar = 32'h8;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_req_before", 32'({mem_req, stall}), 32'h3);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_outs", 32'({mem_req, stall, mdr_load, mbr_load, bus_err}), 32'h0);
        chk("midrst_mdr_rd", mdr_rd, 32'h0);
        chk("midrst_mbr_byte", 32'(mbr_byte), 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        wait_cfg = 0;
        m_mdr = '0; m_mbr = '0; m_err = 1'b0;
        @(negedge clk);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 1, st, ml, bl);
        chk("midrst_fresh_rd", mdr_rd, mem_read(32'h20));

        // Randomized microinstructions; conflicts and hung memory only late in the run
        for (int i = 0; i < 40; i++) begin
            logic        r, w, f, h;
            logic [31:0] a, d, p;
            int          k, ws;
            r = 1'($urandom); w = 1'($urandom); f = 1'($urandom); h = 1'($urandom);
            if (i < 30 && r && w) w = 1'b0;
            a = $urandom_range(0, 63);
            d = $urandom;
            p = $urandom_range(0, 255);
            k = $urandom_range(0, 9);
            ws = (k == 9 && i >= 30) ? HANG : (k % 4);
            do_op(r, w, f, h, a, d, p, ws, st, ml, bl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
